// File: rtl/event_count_pkg.sv
// event_count_pkg: shared state encoding for the event counter controller.
package event_count_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/event_count_ctrl_count_unit.sv
// count_unit: WIDTH-bit up-counter with synchronous clear/enable and a
// lookahead flag telling the FSM that the next increment lands on LIMIT.
module count_unit #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 2**WIDTH - 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             next_is_limit
);
    logic [WIDTH-1:0] next;
    assign next = count + 1'b1;
    assign next_is_limit = next == WIDTH'(LIMIT);
    always_ff @(posedge clock) begin
        if (reset || clear) count <= '0;
        else if (enable) count <= next;
    end
endmodule

// File: rtl/event_count_ctrl.sv
// event_count_ctrl: start-triggered FSM that counts qualified x events up to
// LIMIT, with optional consecutive-run and auto-restart behaviour.
module event_count_ctrl #(
    parameter int WIDTH        = 4,
    parameter int LIMIT        = 2**WIDTH - 1,
    parameter bit CONSECUTIVE  = 1'b0,
    parameter bit AUTO_RESTART = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             x,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             busy,
    output logic [1:0]       state
);
    import event_count_pkg::*;
    if (LIMIT < 1 || longint'(LIMIT) > (longint'(1) << WIDTH) - 1) begin : g_bad_limit
        $error("event_count_ctrl: LIMIT out of range for WIDTH");
    end
    state_t fsm, next;
    logic   run, clear, enable, next_is_limit;
    assign run    = fsm == ARMED || fsm == COUNT;
    // abort freezes the count; start and the re-arm paths zero it
    assign clear  = !abort && (start || (fsm == COUNT && !x && CONSECUTIVE)
                                     || (fsm == DONE && AUTO_RESTART));
    assign enable = !abort && !start && run && x;
    always_comb begin
        next = fsm;
        if (abort) next = IDLE;
        else if (start) next = ARMED;
        else if (run && x) next = next_is_limit ? DONE : COUNT;
        else if (fsm == COUNT && CONSECUTIVE) next = ARMED;
        else if (fsm == DONE && AUTO_RESTART) next = ARMED;
    end
    always_ff @(posedge clock) begin
        fsm  <= reset ? IDLE : next;
        done <= !reset && next == DONE;
        busy <= !reset && (next == ARMED || next == COUNT);
    end
    assign state = fsm;
    count_unit #(.WIDTH(WIDTH), .LIMIT(LIMIT)) u_count (
        .clock         (clock),
        .reset         (reset),
        .clear         (clear),
        .enable        (enable),
        .count         (count),
        .next_is_limit (next_is_limit)
    );
endmodule

// File: doc/event_count_ctrl.md
# event_count_ctrl

Parametrised successor to the team's S/X/Z/G count-until-full controller: a start-triggered FSM plus an up-counter that counts qualified events on `x` and raises `done` when the count reaches a programmable terminal value. Generalised in counter width, terminal count, run mode (cumulative or consecutive), and restart behaviour, with an added abort path. Used as the control/datapath pair inside lab-level integration tops.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits.
- `LIMIT`, 2**WIDTH-1: terminal count. Legal range 1..2**WIDTH-1; out of range is an elaboration error.
- `CONSECUTIVE`, 0: when 1, an `x`=0 cycle during a run clears the count.
- `AUTO_RESTART`, 0: when 1, DONE re-arms automatically after one cycle.

Ports:
- `clock`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  begin or restart a run.
- `x`  in  1  event qualifier; one count per edge while high.
- `abort`  in  1  cancel the current run.
- `count`  out  WIDTH  current count, registered.
- `done`  out  1  terminal count reached, registered.
- `busy`  out  1  high in ARMED or COUNT.
- `state`  out  2  FSM state: IDLE=0, ARMED=1, COUNT=2, DONE=3.

## Operation
- Input priority at each edge: reset > abort > start > x.
- IDLE: `count` and `done` hold. `start` sets count to 0, done to 0, and moves to ARMED. `x` is ignored.
- ARMED: `x`=1 sets count to count+1. If count+1==LIMIT, go to DONE with done set to 1; otherwise go to COUNT. `x`=0 stays in ARMED.
- COUNT: `x`=1 increments under the same LIMIT test. On `x`=0:
  - CONSECUTIVE=0: hold count, stay in COUNT.
  - CONSECUTIVE=1: set count to 0, go to ARMED.
- DONE: `done`=1, count holds at LIMIT, and `x` is ignored.
  - `start` sets count to 0, done to 0, and moves to ARMED.
  - Otherwise, with AUTO_RESTART=1, the next edge sets count to 0, done to 0, and moves to ARMED, so `done` is a one-cycle pulse.
  - With AUTO_RESTART=0, DONE holds indefinitely.
- `start` in ARMED or COUNT restarts the run: count to 0, go to ARMED, and that edge's `x` is ignored.
- `abort` in ARMED, COUNT, or DONE: go to IDLE, count holds its value, done to 0. In IDLE, `abort` has no effect.
- The count never exceeds LIMIT, so there is no wrap-around. Arithmetic is unsigned, modulo 2**WIDTH internally, but the LIMIT test always fires first.

## Timing
- Reset values: state=IDLE, count=0, done=0, busy=0.
- All outputs are registered; there are no combinational input-to-output paths.
- The `start` edge gives count=0 and busy=1 visible in the next cycle.
- `done` rises on the same edge that accepts the LIMIT-th `x`, and `count` shows LIMIT in that same cycle.
- With `x` held high, done is asserted LIMIT edges after the `start` edge.
- LIMIT=1: the first accepted `x` goes from ARMED straight to DONE.
- AUTO_RESTART with `x` held high: a `done` pulse every LIMIT+1 cycles.
- Reset mid-run takes effect on the next edge and overrides all other inputs.

## Structure
- Package `event_count_pkg`: state encoding constants (IDLE/ARMED/COUNT/DONE) and the 2-bit state type.
- Sub-module `count_unit`: WIDTH-bit up-counter with synchronous clear and enable, reporting `next_is_limit` (count+1==LIMIT).
- The FSM lives in `event_count_ctrl` and drives the clear/enable inputs of `count_unit`.

## Test plan
- Defaults; reset, then `start` for 1 cycle, then `x` held high -> count 1..15 on successive edges; done=1 and state=3 on the 15th edge; count then holds at 15.
- CONSECUTIVE=1, LIMIT=4; `x` sequence 1,1,1,0,1,1,1,1 -> count 1,2,3,0,1,2,3,4; done=1 only on the last edge.
- Defaults; `abort` when count=7 -> state=0, count=7, busy=0, done=0; then `start` -> count=0, state=1.
- AUTO_RESTART=1, LIMIT=3, `x` held high -> done pulses high for 1 cycle every 4 cycles; count cycles 1,2,3,0.
- LIMIT=1 with `start` and `x` high on the same edge in IDLE -> ARMED with count=0; the next edge gives count=1 and done=1.
- `reset` asserted with count=9 during COUNT -> next edge gives state=0, count=0, done=0; simultaneous `abort`/`start` that edge are ignored.
